// File: rtl/ecc_mm_arbiter.sv
// ecc_mm_arbiter
// Shares one Montgomery multiplier between two requesters. Round-robin grant,
// operand capture at grant, a single start pulse per job, a watchdog while the
// multiplier runs, and a held response until the owning requester takes it.
module ecc_mm_arbiter #(
   parameter int REG_SIZE       = 384,
   parameter int RADIX          = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                req0_valid_i,
   output logic                req0_ready_o,
   input  logic [REG_SIZE-1:0] req0_opa_i,
   input  logic [REG_SIZE-1:0] req0_opb_i,
   input  logic                req1_valid_i,
   output logic                req1_ready_o,
   input  logic [REG_SIZE-1:0] req1_opa_i,
   input  logic [REG_SIZE-1:0] req1_opb_i,
   input  logic [REG_SIZE-1:0] n_i,
   input  logic [RADIX-1:0]    n_prime_i,
   output logic                rsp0_valid_o,
   input  logic                rsp0_ready_i,
   output logic                rsp1_valid_o,
   input  logic                rsp1_ready_i,
   output logic [REG_SIZE-1:0] rsp_data_o,
   output logic                rsp_err_o,
   output logic                mm_start_o,
   output logic [REG_SIZE-1:0] mm_opa_o,
   output logic [REG_SIZE-1:0] mm_opb_o,
   output logic [REG_SIZE-1:0] mm_n_o,
   output logic [RADIX-1:0]    mm_n_prime_o,
   input  logic [REG_SIZE-1:0] mm_p_i,
   input  logic                mm_ready_i,
   output logic                busy_o,
   output logic                timeout_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic                last_gnt_reg;
   logic                owner_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [REG_SIZE-1:0] opa_reg, opb_reg, n_reg;
   logic [RADIX-1:0]    n_prime_reg;
   logic [REG_SIZE-1:0] rsp_data_reg;
   logic                rsp_err_reg;
   logic                timeout_reg;

   logic [1:0]          req_valid;
   logic [1:0]          req_gnt;
   logic [1:0]          rsp_ready;
   logic [1:0]          rsp_valid;
   logic [REG_SIZE-1:0] req_opa [2];
   logic [REG_SIZE-1:0] req_opb [2];
   logic                in_idle;
   logic                in_resp;
   logic                gnt_any;
   logic                gnt_idx;
   logic                wd_expired;

   assign req_valid  = {req1_valid_i, req0_valid_i};
   assign rsp_ready  = {rsp1_ready_i, rsp0_ready_i};
   assign req_opa[0] = req0_opa_i;
   assign req_opa[1] = req1_opa_i;
   assign req_opb[0] = req0_opb_i;
   assign req_opb[1] = req1_opb_i;

   assign in_idle    = (state_reg == ST_IDLE);
   assign in_resp    = (state_reg == ST_RESP);
   assign wd_expired = (cnt_reg == CNT_LAST);

   // Per-requester grant and response-valid. With both requesters valid the one
   // that was not served last wins; grant is held off while reset is asserted.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_port
         assign req_gnt[gi]   = reset_n && in_idle && req_valid[gi] &&
                                (!req_valid[1-gi] || (last_gnt_reg != 1'(gi)));
         assign rsp_valid[gi] = in_resp && (owner_reg == 1'(gi));
      end
   endgenerate

   assign gnt_any      = |req_gnt;
   assign gnt_idx      = req_gnt[1];

   assign req0_ready_o = req_gnt[0];
   assign req1_ready_o = req_gnt[1];
   assign rsp0_valid_o = rsp_valid[0];
   assign rsp1_valid_o = rsp_valid[1];
   assign rsp_data_o   = rsp_data_reg;
   assign rsp_err_o    = rsp_err_reg;
   assign mm_opa_o     = opa_reg;
   assign mm_opb_o     = opb_reg;
   assign mm_n_o       = n_reg;
   assign mm_n_prime_o = n_prime_reg;
   assign timeout_o    = timeout_reg;

   // Next-state and FSM-decoded outputs.
   always_comb begin
      state_next = state_reg;
      mm_start_o = 1'b0;
      busy_o     = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (gnt_any) state_next = ST_START;
         end
         ST_START: begin
            mm_start_o = 1'b1;
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (mm_ready_i || wd_expired) state_next = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready[owner_reg]) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= ST_IDLE;
      else          state_reg <= state_next;
   end

   // Job capture at grant, watchdog counter, and result/error capture in WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_gnt_reg <= 1'b1;
         owner_reg    <= 1'b0;
         cnt_reg      <= '0;
         opa_reg      <= '0;
         opb_reg      <= '0;
         n_reg        <= '0;
         n_prime_reg  <= '0;
         rsp_data_reg <= '0;
         rsp_err_reg  <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (gnt_any) begin
                  opa_reg      <= req_opa[gnt_idx];
                  opb_reg      <= req_opb[gnt_idx];
                  n_reg        <= n_i;
                  n_prime_reg  <= n_prime_i;
                  owner_reg    <= gnt_idx;
                  last_gnt_reg <= gnt_idx;
               end
            end
            ST_START: begin
               cnt_reg <= '0;
            end
            ST_WAIT: begin
               if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
               // A completion in the last watchdog cycle still counts as success.
               if (mm_ready_i) begin
                  rsp_data_reg <= mm_p_i;
                  rsp_err_reg  <= 1'b0;
               end else if (wd_expired) begin
                  rsp_data_reg <= '0;
                  rsp_err_reg  <= 1'b1;
                  timeout_reg  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ecc_mm_arbiter.sv
// Testbench for ecc_mm_arbiter: table of single jobs, hand-written corner
// sequences, and a randomized run checked against a transaction-level model.
module tb_ecc_mm_arbiter;

   localparam int RS = 384;
   localparam int RX = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          req0_valid_i = 1'b0, req1_valid_i = 1'b0;
   logic          req0_ready_o, req1_ready_o;
   logic [RS-1:0] req0_opa_i = '0, req0_opb_i = '0, req1_opa_i = '0, req1_opb_i = '0;
   logic [RS-1:0] n_i = '0;
   logic [RX-1:0] n_prime_i = '0;
   logic          rsp0_valid_o, rsp1_valid_o;
   logic          rsp0_ready_i = 1'b0, rsp1_ready_i = 1'b0;
   logic [RS-1:0] rsp_data_o;
   logic          rsp_err_o;
   logic          mm_start_o;
   logic [RS-1:0] mm_opa_o, mm_opb_o, mm_n_o;
   logic [RX-1:0] mm_n_prime_o;
   logic [RS-1:0] mm_p_i;
   logic          mm_ready_i;
   logic          busy_o, timeout_o;

   // multiplier model state
   logic [RS-1:0] model_p = '0;
   logic [RS-1:0] junk_p = '0;
   logic          model_rdy = 1'b0;
   logic          inj_rdy = 1'b0;
   int            mm_lat = 38;     // 0 = never answers
   int            mcnt = 0;
   int            start_total = 0;

   int tests = 0;
   int failed = 0;

   assign mm_ready_i = model_rdy | inj_rdy;
   assign mm_p_i     = inj_rdy ? junk_p : model_p;

   ecc_mm_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_opa_i(req0_opa_i), .req0_opb_i(req0_opb_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_opa_i(req1_opa_i), .req1_opb_i(req1_opb_i),
      .n_i(n_i), .n_prime_i(n_prime_i),
      .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
      .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .mm_start_o(mm_start_o), .mm_opa_o(mm_opa_o), .mm_opb_o(mm_opb_o),
      .mm_n_o(mm_n_o), .mm_n_prime_o(mm_n_prime_o),
      .mm_p_i(mm_p_i), .mm_ready_i(mm_ready_i),
      .busy_o(busy_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   // Multiplier model: answers (a*b) mod n mm_lat cycles after a start pulse.
   always @(negedge clk) begin
      model_rdy = 1'b0;
      if (!reset_n) begin
         mcnt = 0;
      end else if (mm_start_o) begin
         start_total++;
         mcnt = mm_lat;
      end else if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            model_rdy = 1'b1;
            model_p   = (mm_opa_o * mm_opb_o) % mm_n_o;
         end
      end
   end

   task automatic chk(input string name, input logic [RS-1:0] act, input logic [RS-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int who, input logic v, input logic [RS-1:0] a, input logic [RS-1:0] b);
      if (who == 0) begin
         req0_valid_i = v; req0_opa_i = a; req0_opb_i = b;
      end else begin
         req1_valid_i = v; req1_opa_i = a; req1_opb_i = b;
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},   RS'(busy_o), '0);
      chk({tag, "_start"},  RS'(mm_start_o), '0);
      chk({tag, "_rsp0v"},  RS'(rsp0_valid_o), '0);
      chk({tag, "_rsp1v"},  RS'(rsp1_valid_o), '0);
      chk({tag, "_data"},   rsp_data_o, '0);
      chk({tag, "_err"},    RS'(rsp_err_o), '0);
      chk({tag, "_tmo"},    RS'(timeout_o), '0);
      chk({tag, "_opa"},    mm_opa_o, '0);
      chk({tag, "_opb"},    mm_opb_o, '0);
      chk({tag, "_n"},      mm_n_o, '0);
      chk({tag, "_nprime"}, RS'(mm_n_prime_o), '0);
   endtask

   task automatic do_reset();
      step();
      reset_n = 1'b0;
      @(negedge clk);
      step();
      reset_n = 1'b1;
   endtask

   typedef struct {
      int            who;
      logic [RS-1:0] a, b, n;
      int            lat;
      int            hold;
      logic [RS-1:0] exp_d;
      logic          exp_e;
      logic          exp_to;
   } vec_t;

   // One complete job for requester v.who, compared against the record.
   task automatic run_job(input string tag, input vec_t v);
      logic          hs;
      logic [RS-1:0] d0;
      logic [RX-1:0] np;
      int            s0;
      int            oth;
      oth = 1 - v.who;
      s0  = start_total;
      np  = RX'(32'hA5A5_0000 | v.lat);
      mm_lat = v.lat;
      step();
      set_req(v.who, 1'b1, v.a, v.b);
      n_i = v.n;
      n_prime_i = np;
      hs = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         hs = (v.who == 1) ? req1_ready_o : req0_ready_o;
         if (hs) break;
      end
      chk({tag, "_grant"}, RS'(hs), RS'(1'b1));
      step();
      // scramble requester inputs: the captured copies must be used
      set_req(v.who, 1'b0, RS'($urandom), RS'($urandom));
      n_i = '1;
      n_prime_i = '1;
      hs = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         hs = (v.who == 1) ? rsp1_valid_o : rsp0_valid_o;
         if (hs) break;
      end
      chk({tag, "_rsp_seen"}, RS'(hs), RS'(1'b1));
      d0 = rsp_data_o;
      if (v.hold > 0) begin
         step();
         set_req(oth, 1'b1, RS'(99), RS'(98));
         for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_data"}, rsp_data_o, d0);
            chk({tag, "_hold_busy"}, RS'(busy_o), RS'(1'b1));
            chk({tag, "_hold_nogrant"}, RS'((oth == 1) ? req1_ready_o : req0_ready_o), '0);
         end
      end
      step();
      set_req(oth, 1'b0, '0, '0);
      if (v.who == 1) rsp1_ready_i = 1'b1; else rsp0_ready_i = 1'b1;
      @(negedge clk);
      chk({tag, "_data"}, rsp_data_o, v.exp_d);
      chk({tag, "_err"}, RS'(rsp_err_o), RS'(v.exp_e));
      chk({tag, "_own_valid"}, RS'((v.who == 1) ? rsp1_valid_o : rsp0_valid_o), RS'(1'b1));
      chk({tag, "_other_valid"}, RS'((v.who == 1) ? rsp0_valid_o : rsp1_valid_o), '0);
      chk({tag, "_mm_opa"}, mm_opa_o, v.a);
      chk({tag, "_mm_opb"}, mm_opb_o, v.b);
      chk({tag, "_mm_n"}, mm_n_o, v.n);
      chk({tag, "_mm_nprime"}, RS'(mm_n_prime_o), RS'(np));
      chk({tag, "_timeout_flag"}, RS'(timeout_o), RS'(v.exp_to));
      chk({tag, "_starts"}, RS'(start_total - s0), RS'(1));
      step();
      rsp0_ready_i = 1'b0;
      rsp1_ready_i = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_busy"}, RS'(busy_o), '0);
      chk({tag, "_idle_rspv"}, RS'(rsp0_valid_o | rsp1_valid_o), '0);
   endtask

   typedef struct {
      int            who;
      logic [RS-1:0] d;
   } job_t;

   vec_t tbl[7];

   initial begin
      logic          hs;
      int            grants;
      int            s0;
      int            jobs;
      int            prev_w;
      int            exp_w;
      int            w;
      logic          pend[2];
      logic [RS-1:0] pa[2];
      logic [RS-1:0] pb[2];
      job_t          q[$];
      vec_t          v;

      // who, a, b, n, latency, hold, expected data, err, sticky timeout
      tbl[0] = '{0, RS'(2),   RS'(3),   RS'(7),    38, 0,  RS'(6),  1'b0, 1'b0};
      tbl[1] = '{1, RS'(5),   RS'(5),   RS'(11),   1,  20, RS'(3),  1'b0, 1'b0};
      tbl[2] = '{0, RS'(10),  RS'(20),  RS'(97),   64, 0,  RS'(6),  1'b0, 1'b0};
      tbl[3] = '{1, RS'(123), RS'(456), RS'(1000), 5,  3,  RS'(88), 1'b0, 1'b0};
      tbl[4] = '{0, RS'(9),   RS'(9),   RS'(13),   65, 0,  RS'(0),  1'b1, 1'b1};
      tbl[5] = '{1, RS'(4),   RS'(4),   RS'(5),    0,  2,  RS'(0),  1'b1, 1'b1};
      tbl[6] = '{0, RS'(7),   RS'(8),   RS'(100),  2,  0,  RS'(56), 1'b0, 1'b1};

      // reset state
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      chk("reset_ready0", RS'(req0_ready_o), '0);
      chk("reset_ready1", RS'(req1_ready_o), '0);
      step();
      reset_n = 1'b1;

      for (int i = 0; i < 7; i++) run_job($sformatf("vec%0d", i), tbl[i]);

      // spurious mm_ready in IDLE and in START are ignored
      do_reset();
      junk_p = RS'(32'hDEAD_BEEF);
      inj_rdy = 1'b1;
      @(negedge clk);
      chk("spur_idle_busy", RS'(busy_o), '0);
      step();
      inj_rdy = 1'b0;
      @(negedge clk);
      chk("spur_idle_rspv", RS'(rsp0_valid_o | rsp1_valid_o), '0);
      chk("spur_idle_data", rsp_data_o, '0);
      s0 = start_total;
      mm_lat = 10;
      step();
      set_req(0, 1'b1, RS'(6), RS'(7));
      n_i = RS'(50);
      @(negedge clk);
      chk("spur_grant", RS'(req0_ready_o), RS'(1'b1));
      step();
      set_req(0, 1'b0, '0, '0);
      inj_rdy = 1'b1;
      @(negedge clk);
      chk("spur_start_pulse", RS'(mm_start_o), RS'(1'b1));
      step();
      inj_rdy = 1'b0;
      @(negedge clk);
      chk("spur_start_ignored", RS'(rsp0_valid_o), '0);
      hs = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         hs = rsp0_valid_o;
         if (hs) break;
      end
      chk("spur_rsp_seen", RS'(hs), RS'(1'b1));
      chk("spur_data", rsp_data_o, RS'(42));
      chk("spur_err", RS'(rsp_err_o), '0);
      chk("spur_starts", RS'(start_total - s0), RS'(1));
      step();
      rsp0_ready_i = 1'b1;
      step();
      rsp0_ready_i = 1'b0;

      // both requesters valid from reset: grants alternate 0,1,0,1,...
      step();
      reset_n = 1'b0;
      set_req(0, 1'b1, RS'(1), RS'(2));
      set_req(1, 1'b1, RS'(3), RS'(4));
      n_i = RS'(1000);
      rsp0_ready_i = 1'b1;
      rsp1_ready_i = 1'b1;
      mm_lat = 3;
      @(negedge clk);
      step();
      reset_n = 1'b1;
      grants = 0;
      for (int k = 0; k < 400 && grants < 8; k++) begin
         @(negedge clk);
         if (req0_ready_o && req1_ready_o) chk("alt_double_grant", RS'(1), '0);
         if (req0_ready_o || req1_ready_o) begin
            chk($sformatf("alt_grant%0d", grants), RS'(req1_ready_o), RS'(grants % 2));
            grants++;
         end
         if (rsp0_valid_o) chk("alt_rsp0_data", rsp_data_o, RS'(2));
         if (rsp1_valid_o) chk("alt_rsp1_data", rsp_data_o, RS'(12));
      end
      chk("alt_grant_count", RS'(grants), RS'(8));
      step();
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!busy_o) break;
      end
      rsp0_ready_i = 1'b0;
      rsp1_ready_i = 1'b0;

      // reset asserted mid-WAIT: everything clears at once, next job is clean
      mm_lat = 30;
      step();
      set_req(1, 1'b1, RS'(11), RS'(12));
      n_i = RS'(77);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (req1_ready_o) break;
      end
      step();
      set_req(1, 1'b0, '0, '0);
      repeat (5) @(negedge clk);
      chk("midrst_busy_before", RS'(busy_o), RS'(1'b1));
      step();
      reset_n = 1'b0;
      @(negedge clk);
      chk_all_zero("midrst");
      step();
      reset_n = 1'b1;
      v = '{1, RS'(3), RS'(3), RS'(5), 4, 0, RS'(4), 1'b0, 1'b0};
      run_job("after_rst", v);

      // randomized traffic against a transaction-level scoreboard
      do_reset();
      s0 = start_total;
      jobs = 0;
      prev_w = 1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         step();
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               pa[i] = RS'($urandom_range(1, 65535));
               pb[i] = RS'($urandom_range(1, 65535));
            end
            set_req(i, pend[i], pa[i], pb[i]);
         end
         rsp0_ready_i = 1'($urandom_range(0, 1));
         rsp1_ready_i = 1'($urandom_range(0, 1));
         n_i = RS'($urandom_range(1, 65535));
         mm_lat = $urandom_range(1, 30);
         @(negedge clk);
         if (req0_ready_o || req1_ready_o) begin
            w = req1_ready_o ? 1 : 0;
            exp_w = (pend[0] && pend[1]) ? (1 - prev_w) : (pend[0] ? 0 : 1);
            chk("rnd_grant", RS'(w), RS'(exp_w));
            chk("rnd_single_grant", RS'(req0_ready_o & req1_ready_o), '0);
            chk("rnd_in_flight", RS'(q.size()), '0);
            q.push_back('{w, (pa[w] * pb[w]) % n_i});
            prev_w = w;
            pend[w] = 1'b0;
            jobs++;
         end
         if (rsp0_valid_o || rsp1_valid_o) begin
            if (q.size() == 0) begin
               chk("rnd_unexpected_rsp", RS'(1), '0);
            end else begin
               chk("rnd_owner", RS'(rsp1_valid_o), RS'(q[0].who));
               chk("rnd_data", rsp_data_o, q[0].d);
               chk("rnd_err", RS'(rsp_err_o), '0);
               if ((q[0].who == 0 && rsp0_ready_i) || (q[0].who == 1 && rsp1_ready_i))
                  void'(q.pop_front());
            end
         end
      end
      step();
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);
      rsp0_ready_i = 1'b1;
      rsp1_ready_i = 1'b1;
      for (int k = 0; k < 200 && q.size() > 0; k++) begin
         @(negedge clk);
         if (rsp0_valid_o || rsp1_valid_o) begin
            chk("rnd_drain_data", rsp_data_o, q[0].d);
            void'(q.pop_front());
         end
      end
      chk("rnd_drained", RS'(q.size()), '0);
      chk("rnd_starts_eq_jobs", RS'(start_total - s0), RS'(jobs));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
